// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Brief    : PLL-lock gated, staggered multi-domain reset release with
//            full-system and per-domain re-reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int CLK_FREQ    = 96_000_000,
    parameter int NUM_OUT     = 4,
    parameter int STAGE_DELAY = CLK_FREQ / 1000,
    parameter int LOCK_FILTER = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               nreset_in,
    input  logic               pll_locked,
    input  logic               sw_reset_req,
    input  logic [NUM_OUT-1:0] domain_reset_req,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               all_ready,
    output logic [1:0]         seq_state
);

    localparam int CW = $clog2(STAGE_DELAY + 1);
    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int IW = $clog2(NUM_OUT + 1);

    localparam logic [CW-1:0] c_STAGE_RELOAD = CW'(STAGE_DELAY - 1);
    localparam logic [LW-1:0] c_LOCK_LAST    = LW'(LOCK_FILTER - 1);
    localparam logic [LW-1:0] c_LOCK_MAX     = LW'(LOCK_FILTER);
    localparam logic [IW-1:0] c_IDX_LAST     = IW'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_OUT-1:0]          reset_out_q, reset_out_d;
    logic                        all_ready_q, all_ready_d;
    logic [LW-1:0]               lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]               stage_cnt_q, stage_cnt_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_OUT-1:0][CW-1:0]  dcnt_q, dcnt_d;
    logic [SYNC_STAGES-1:0]      rst_sync_q;
    logic [SYNC_STAGES-1:0]      lock_sync_q;

    logic w_rst_done;
    logic w_locked;

    assign w_rst_done = rst_sync_q[SYNC_STAGES-1];
    assign w_locked   = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        reset_out_d = reset_out_q;
        lock_cnt_d  = lock_cnt_q;
        stage_cnt_d = stage_cnt_q;
        idx_d       = idx_q;
        dcnt_d      = dcnt_q;

        // Lock loss outranks a software request; both drop any domain request.
        if ((state_q != S_HOLD) && (!w_locked || sw_reset_req)) begin
            state_d     = S_WAIT_LOCK;
            reset_out_d = '1;
            lock_cnt_d  = '0;
            stage_cnt_d = '0;
            idx_d       = '0;
            dcnt_d      = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (w_rst_done) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_cnt_q == c_LOCK_LAST) begin
                        state_d     = S_RELEASE;
                        idx_d       = '0;
                        stage_cnt_d = c_STAGE_RELOAD;
                    end else if (lock_cnt_q != c_LOCK_MAX) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (stage_cnt_q == '0) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (IW'(i) == idx_q) begin
                                reset_out_d[i] = 1'b0;
                            end
                        end
                        idx_d       = idx_q + 1'b1;
                        stage_cnt_d = c_STAGE_RELOAD;
                        if (idx_q == c_IDX_LAST) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        stage_cnt_d = stage_cnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    // A request while a pulse is pending reloads its counter.
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (domain_reset_req[i]) begin
                            reset_out_d[i] = 1'b1;
                            dcnt_d[i]      = c_STAGE_RELOAD;
                        end else if (reset_out_q[i]) begin
                            if (dcnt_q[i] == '0) begin
                                reset_out_d[i] = 1'b0;
                            end else begin
                                dcnt_d[i] = dcnt_q[i] - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end

        // Falls with any asserting reset, rises one cycle after all are clear.
        all_ready_d = (state_q == S_RUN) && (state_d == S_RUN) &&
                      (reset_out_q == '0) && (reset_out_d == '0);
    end

    always_ff @(posedge clk or negedge nreset_in) begin
        if (!nreset_in) begin
            state_q     <= S_HOLD;
            reset_out_q <= '1;
            all_ready_q <= 1'b0;
            lock_cnt_q  <= '0;
            stage_cnt_q <= '0;
            idx_q       <= '0;
            dcnt_q      <= '0;
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q     <= state_d;
            reset_out_q <= reset_out_d;
            all_ready_q <= all_ready_d;
            lock_cnt_q  <= lock_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            idx_q       <= idx_d;
            dcnt_q      <= dcnt_d;
        end
    end

    assign reset_out = reset_out_q;
    assign all_ready = all_ready_q;
    assign seq_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Directed self-checking bench for reset_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       nreset_in = 1'b1;
    logic       pll_locked = 1'b1;
    logic       sw_reset_req = 1'b0;
    logic [2:0] domain_reset_req = 3'b000;
    logic [2:0] reset_out;
    logic       all_ready;
    logic [1:0] seq_state;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(
        .CLK_FREQ   (4000),
        .NUM_OUT    (3),
        .STAGE_DELAY(4),
        .LOCK_FILTER(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk             (clk),
        .nreset_in       (nreset_in),
        .pll_locked      (pll_locked),
        .sw_reset_req    (sw_reset_req),
        .domain_reset_req(domain_reset_req),
        .reset_out       (reset_out),
        .all_ready       (all_ready),
        .seq_state       (seq_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assumes nreset_in was just raised right after a clock edge, lock held.
    task automatic power_up(input string p);
        tick(2);  chk({p, "_hold"},      32'(seq_state), 0);
        tick(1);  chk({p, "_waitlock"},  32'(seq_state), 1);
        tick(7);  chk({p, "_waitlock7"}, 32'(seq_state), 1);
        tick(1);  chk({p, "_rel_entry"}, 32'(seq_state), 2);
                  chk({p, "_rel_rst"},   32'(reset_out), 3'b111);
        tick(3);  chk({p, "_rel_p3"},    32'(reset_out), 3'b111);
        tick(1);  chk({p, "_rel_p4"},    32'(reset_out), 3'b110);
        tick(4);  chk({p, "_rel_p8"},    32'(reset_out), 3'b100);
        tick(3);  chk({p, "_rel_p11"},   32'(reset_out), 3'b100);
        tick(1);  chk({p, "_rel_p12"},   32'(reset_out), 3'b000);
                  chk({p, "_run"},       32'(seq_state), 3);
                  chk({p, "_rdy_lag"},   32'(all_ready), 0);
        tick(1);  chk({p, "_rdy"},       32'(all_ready), 1);
    endtask

    initial begin
        // Reset state
        #2 nreset_in = 1'b0;
        tick(3);
        chk("rst_out",   32'(reset_out), 3'b111);
        chk("rst_rdy",   32'(all_ready), 0);
        chk("rst_state", 32'(seq_state), 0);

        // Scenario 1: power-up
        nreset_in = 1'b1;
        power_up("pu1");

        // Scenario 3: single domain pulse, then an extended one
        domain_reset_req = 3'b100; tick(1); domain_reset_req = 3'b000;
        chk("dom_e0",     32'(reset_out), 3'b100);
        chk("dom_e0_rdy", 32'(all_ready), 0);
        tick(3); chk("dom_e3", 32'(reset_out), 3'b100);
        tick(1); chk("dom_e4", 32'(reset_out), 3'b000);
                 chk("dom_e4_rdy", 32'(all_ready), 0);
        tick(1); chk("dom_e5_rdy", 32'(all_ready), 1);

        domain_reset_req = 3'b100; tick(1); domain_reset_req = 3'b000;
        tick(1);
        domain_reset_req = 3'b100; tick(1); domain_reset_req = 3'b000;
        chk("ext_e2", 32'(reset_out), 3'b100);
        tick(3); chk("ext_e5", 32'(reset_out), 3'b100);
                 chk("ext_e5_rdy", 32'(all_ready), 0);
        tick(1); chk("ext_e6", 32'(reset_out), 3'b000);
        tick(1); chk("ext_e7_rdy", 32'(all_ready), 1);

        // Scenario 5: software request beats a same-cycle domain request
        sw_reset_req = 1'b1; domain_reset_req = 3'b001;
        tick(1);
        sw_reset_req = 1'b0; domain_reset_req = 3'b000;
        chk("sw_out",   32'(reset_out), 3'b111);
        chk("sw_state", 32'(seq_state), 1);
        chk("sw_rdy",   32'(all_ready), 0);
        tick(7);  chk("sw_wait7", 32'(seq_state), 1);
        tick(1);  chk("sw_rel",   32'(seq_state), 2);
        tick(12); chk("sw_done",  32'(reset_out), 3'b000);
                  chk("sw_run",   32'(seq_state), 3);
        tick(1);  chk("sw_rdy2",  32'(all_ready), 1);

        // Scenario 2: lock glitch during WAIT_LOCK restarts the filter
        sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0;
        tick(2);
        pll_locked = 1'b0; tick(1); pll_locked = 1'b1;
        tick(5); chk("glitch_r8",  32'(seq_state), 1);
        tick(4); chk("glitch_r12", 32'(seq_state), 1);
        tick(1); chk("glitch_rel", 32'(seq_state), 2);
        tick(4); chk("glitch_l4",  32'(reset_out), 3'b110);

        // Scenario 4: lock loss mid-RELEASE re-asserts released bits
        pll_locked = 1'b0;
        tick(2); chk("loss_l6_out",   32'(reset_out), 3'b110);
                 chk("loss_l6_state", 32'(seq_state), 2);
        tick(1); chk("loss_l7_out",   32'(reset_out), 3'b111);
                 chk("loss_l7_state", 32'(seq_state), 1);
        tick(2);
        pll_locked = 1'b1;
        tick(9); chk("relock_wait", 32'(seq_state), 1);
        tick(1); chk("relock_rel",  32'(seq_state), 2);
        tick(4); chk("relock_out",  32'(reset_out), 3'b110);

        // Scenario 6: asynchronous reset between edges, mid-RELEASE
        #2 nreset_in = 1'b0;
        #1;
        chk("async_out",   32'(reset_out), 3'b111);
        chk("async_state", 32'(seq_state), 0);
        chk("async_rdy",   32'(all_ready), 0);
        tick(2);
        chk("async_hold", 32'(seq_state), 0);
        nreset_in = 1'b1;
        power_up("pu2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generalised reset generator for the SoC clock domain.
- Gates reset release on PLL lock, then releases NUM_OUT active-high reset outputs in a staggered sequence (reset_out[0] first).
- Supports full-system re-reset on lock loss or software request.
- Supports per-domain re-reset, e.g. video pipeline on video_mode change, without disturbing the other domains.

Parameters:
- CLK_FREQ, 96_000_000: clk frequency in Hz; documentation and default derivation only.
- NUM_OUT, 4: number of reset outputs; must be >= 1.
- STAGE_DELAY, CLK_FREQ/1000: cycles between successive releases, and the length of a per-domain re-reset pulse; must be >= 1.
- LOCK_FILTER, 64: consecutive synchronised pll_locked=1 cycles required before release starts; must be >= 1.
- SYNC_STAGES, 2: synchroniser depth for pll_locked and for nreset_in deassertion; must be >= 2.

Ports:
- clk, input, 1: single clock; all logic in this domain.
- nreset_in, input, 1: asynchronous, active-low reset.
- pll_locked, input, 1: PLL lock indicator; asynchronous, synchronised internally.
- sw_reset_req, input, 1: single-cycle pulse; requests a full re-sequence.
- domain_reset_req, input, NUM_OUT: per-bit pulse; requests re-reset of domain i only.
- reset_out, output, NUM_OUT: active-high domain resets.
- all_ready, output, 1: 1 when every reset_out bit is 0.
- seq_state, output, 2: debug encoding: 0=HOLD, 1=WAIT_LOCK, 2=RELEASE, 3=RUN.

Behaviour:
- Reset (nreset_in=0) clears asynchronously and immediately:
  - reset_out=all ones, all_ready=0, seq_state=HOLD.
  - Lock counter, stage counter, stage index, per-domain counters and synchronisers all 0.
- nreset_in deassertion is synchronised through SYNC_STAGES flops.
- HOLD -> WAIT_LOCK on the first cycle the synchronised reset reads deasserted.
- WAIT_LOCK:
  - lock_cnt increments while synced pll_locked=1 and clears to 0 on any synced 0.
  - When lock_cnt reaches LOCK_FILTER-1 with lock still high: enter RELEASE, idx=0, stage_cnt=STAGE_DELAY-1.
- RELEASE:
  - stage_cnt decrements each cycle.
  - On the cycle stage_cnt=0: reset_out[idx]<=0 and idx++; stage_cnt reloads STAGE_DELAY-1.
  - When idx reaches NUM_OUT: enter RUN.
  - reset_out[0] falls exactly STAGE_DELAY cycles after entering RELEASE; each later bit falls STAGE_DELAY cycles after the previous one.
- RUN, per-domain re-reset:
  - domain_reset_req[i]=1 sets reset_out[i]<=1 and dcnt[i]<=STAGE_DELAY-1.
  - dcnt[i] decrements; reset_out[i]<=0 on the cycle dcnt[i]=0.
  - A repeat request while pending reloads dcnt[i], extending the pulse.
- all_ready is registered: 1 in RUN when reset_out==0; otherwise 0.
- Full re-sequence, from any state other than HOLD, on synced pll_locked=0 or sw_reset_req=1:
  - Next cycle: reset_out=all ones, all_ready=0, all counters cleared, state=WAIT_LOCK.
- Priority, highest first: nreset_in > lock loss > sw_reset_req > domain_reset_req.
  - A domain request in the same cycle as a full re-sequence is dropped.
- domain_reset_req is ignored in HOLD, WAIT_LOCK and RELEASE.
- Lock loss during RELEASE aborts the sequence; bits already released are re-asserted.
- Counter width:
  - stage/dcnt counters are $clog2(STAGE_DELAY+1) bits.
  - lock_cnt is $clog2(LOCK_FILTER+1) bits and saturates; no wrap.
  - idx is $clog2(NUM_OUT+1) bits.
- No combinational path from any input to any output.

Test Plan:
Bench parameters: NUM_OUT=3, STAGE_DELAY=4, LOCK_FILTER=8, SYNC_STAGES=2.
1. Power-up with pll_locked=1 held, then nreset_in 0->1 -> after sync, WAIT_LOCK for 8 cycles; reset_out goes 111->110->100->000 at +4, +8, +12 cycles after RELEASE entry; all_ready=1 one cycle after 000.
2. pll_locked toggles 1,1,1,0,1... during WAIT_LOCK -> lock_cnt restarts; release begins only after 8 uninterrupted synced-high cycles.
3. In RUN, pulse domain_reset_req=3'b100 -> reset_out=100 for exactly 4 cycles, all_ready=0 over that span plus 1, domains 0 and 1 remain 0; a second pulse 2 cycles in -> reset_out[2] high for 6 cycles total.
4. In RELEASE, with reset_out=110, drop pll_locked -> after sync latency reset_out=111, seq_state=WAIT_LOCK; restore lock -> full 8+12-cycle sequence repeats.
5. In RUN, sw_reset_req and domain_reset_req=3'b001 in the same cycle -> reset_out=111 next cycle, state=WAIT_LOCK, domain request has no lingering effect.
6. nreset_in pulled low mid-RELEASE, asynchronously between clock edges -> reset_out=111 and seq_state=0 immediately, without a clock edge; release after deassert follows scenario 1 timing.
